skid_ctrl_gen_mc: RTL and testbench

Multi-channel, multi-level skid buffer control generator for the shared-memory allocation path of SCU.memShare(). Each of `CH_NUM` channels keeps a saturating skid level in `0..SKID_DEPTH` and a run-length counter of consecutive isGtr events, and applies SCU.memShare() design rules 1–3 per channel. The block sits between the RFMU (isGtr source) and the per-channel skid buffer multiplexers, and replaces the single-channel, single-stage skid control generator. With `CH_NUM=1, SKID_DEPTH=1` it is cycle-equivalent to that single-channel generator.

---
 rtl/skid_ctrl_gen_mc.sv | 128 ++++++++++++
 tb/tb_skid_ctrl_gen_mc.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/skid_ctrl_gen_mc.sv
// skid_ctrl_gen_mc
//   Multi-channel skid control generator for the shared-memory allocation
//   path. Each channel owns a saturating skid level (0..SKID_DEPTH), a
//   run-length counter of consecutive isGtr cycles and a sticky overflow flag.
//   The level is raised by isGtr while there is room (rule 1). It is released
//   by a registered back-to-back run (rule 2) or by isGtr coinciding with a
//   pipeline-cycle begin (rule 3).
//
//   Ports
//     sys_clk           clock, rising edge
//     rst               asynchronous active-high reset
//     en_i              advance qualifier; low freezes all state
//     clr_i             synchronous clear of every channel, beats en_i
//     pipeCycle_begin_i shared pipeline-cycle start
//     isGtr_i           per-channel isGtr from RFMU
//     skid_lvl_o        per-channel skid level, channel c at [c*LVL_W +: LVL_W]
//     isColAddr_skid_o  per-channel level != 0
//     skid_ovf_o        per-channel sticky overflow

// Per-channel slice: one skid level, run counter and overflow flag.
//   Ports: sys_clk, rst, en, clr, pcb (pipeline begin), gtr (isGtr),
//          lvl / col / ovf (registered level, level != 0, sticky overflow).
module skid_ch #(
  parameter int MAX_ALLOC_SEQ_NUM = 2,
  parameter int SKID_DEPTH        = 2,
  parameter int LVL_W             = 2,
  parameter int CNT_W             = 2
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             pcb,
  input  logic             gtr,
  output logic [LVL_W-1:0] lvl,
  output logic             col,
  output logic             ovf
);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(SKID_DEPTH);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_ALLOC_SEQ_NUM + 1);

  logic [CNT_W-1:0] run, run_nxt;
  logic [LVL_W-1:0] lvl_nxt;
  logic             ovf_nxt, b2b, full;

  // b2b looks only at the registered run, so rule 2 fires one edge after the
  // qualifying history is complete, never on the current input.
  assign b2b  = (run == RUN_MAX);
  assign full = (lvl == LVL_MAX);

  always_comb begin
    run_nxt = run;
    lvl_nxt = lvl;
    ovf_nxt = ovf;
    if (clr) begin
      run_nxt = '0;
      lvl_nxt = '0;
      ovf_nxt = 1'b0;
    end else if (en) begin
      if (gtr) run_nxt = b2b ? run : run + CNT_W'(1);
      else     run_nxt = '0;

      // Rule order matters: increment beats both release rules.
      if (gtr && !full)    lvl_nxt = lvl + LVL_W'(1);
      else if (b2b)        lvl_nxt = '0;
      else if (gtr && pcb) lvl_nxt = '0;

      // Request while full with nothing releasing it.
      if (gtr && full && !b2b && !pcb) ovf_nxt = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      run <= '0;
      lvl <= '0;
      ovf <= 1'b0;
    end else begin
      run <= run_nxt;
      lvl <= lvl_nxt;
      ovf <= ovf_nxt;
    end
  end

  assign col = |lvl;
endmodule

module skid_ctrl_gen_mc #(
  parameter int CH_NUM            = 4,
  parameter int MAX_ALLOC_SEQ_NUM = 2,
  parameter int SKID_DEPTH        = 2,
  parameter int LVL_W             = $clog2(SKID_DEPTH + 1),
  parameter int CNT_W             = $clog2(MAX_ALLOC_SEQ_NUM + 2)
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     clr_i,
  input  logic                     pipeCycle_begin_i,
  input  logic [CH_NUM-1:0]        isGtr_i,
  output logic [CH_NUM*LVL_W-1:0]  skid_lvl_o,
  output logic [CH_NUM-1:0]        isColAddr_skid_o,
  output logic [CH_NUM-1:0]        skid_ovf_o
);
  logic [CH_NUM-1:0][LVL_W-1:0] lvl;

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    skid_ch #(
      .MAX_ALLOC_SEQ_NUM (MAX_ALLOC_SEQ_NUM),
      .SKID_DEPTH        (SKID_DEPTH),
      .LVL_W             (LVL_W),
      .CNT_W             (CNT_W)
    ) u_ch (
      .sys_clk (sys_clk),
      .rst     (rst),
      .en      (en_i),
      .clr     (clr_i),
      .pcb     (pipeCycle_begin_i),
      .gtr     (isGtr_i[c]),
      .lvl     (lvl[c]),
      .col     (isColAddr_skid_o[c]),
      .ovf     (skid_ovf_o[c])
    );
  end

  // Packed array flattens so that channel c lands at [c*LVL_W +: LVL_W].
  assign skid_lvl_o = lvl;
endmodule

// File: tb/tb_skid_ctrl_gen_mc.sv
module tb_skid_ctrl_gen_mc;
  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_i = 1'b0, clr_i = 1'b0, pcb = 1'b0;
  logic [3:0] gtr = '0;
  logic [7:0] skid_lvl_o;
  logic [3:0] isColAddr_skid_o, skid_ovf_o;

  // single-channel, single-stage instance for the legacy comparison
  logic l_en = 1'b0, l_clr = 1'b0, l_pcb = 1'b0;
  logic [0:0] l_gtr = '0, l_lvl, l_col, l_ovf;

  always #5 sys_clk = ~sys_clk;

  skid_ctrl_gen_mc #(.CH_NUM(4), .MAX_ALLOC_SEQ_NUM(2), .SKID_DEPTH(2)) dut (
    .sys_clk(sys_clk), .rst(rst), .en_i(en_i), .clr_i(clr_i),
    .pipeCycle_begin_i(pcb), .isGtr_i(gtr), .skid_lvl_o(skid_lvl_o),
    .isColAddr_skid_o(isColAddr_skid_o), .skid_ovf_o(skid_ovf_o));

  skid_ctrl_gen_mc #(.CH_NUM(1), .MAX_ALLOC_SEQ_NUM(2), .SKID_DEPTH(1)) u_leg (
    .sys_clk(sys_clk), .rst(rst), .en_i(l_en), .clr_i(l_clr),
    .pipeCycle_begin_i(l_pcb), .isGtr_i(l_gtr), .skid_lvl_o(l_lvl),
    .isColAddr_skid_o(l_col), .skid_ovf_o(l_ovf));

  typedef struct packed {
    logic [7:0] lvl;
    logic [3:0] col;
    logic [3:0] ovf;
  } exp_t;

  exp_t sb[$];
  logic lsb[$];
  int   errors = 0, checks = 0;

  function automatic exp_t mk(input logic [1:0] l0, l1, l2, l3, input logic [3:0] o);
    exp_t e;
    e.lvl = {l3, l2, l1, l0};
    e.col = {|l3, |l2, |l1, |l0};
    e.ovf = o;
    return e;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clr_pulse();
    en_i = 1'b1; clr_i = 1'b1; gtr = '0; pcb = 1'b0;
    tick();
    clr_i = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    #3;
    sb.push_back(mk(0, 0, 0, 0, 4'b0));
    tick();
    e = sb.pop_front();
    checks++;
    if ({skid_lvl_o, isColAddr_skid_o, skid_ovf_o} !== e) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", {skid_lvl_o, isColAddr_skid_o, skid_ovf_o}, e);
    end
    rst = 1'b0;
    en_i = 1'b1;
    sb.push_back(mk(0, 0, 0, 0, 4'b0));
    tick();
    e = sb.pop_front();
    checks++;
    if ({skid_lvl_o, isColAddr_skid_o, skid_ovf_o} !== e) begin
      errors++;
      $display("FAIL reset_release got=%h exp=%h", {skid_lvl_o, isColAddr_skid_o, skid_ovf_o}, e);
    end
  endtask

  // ch0 isGtr held high: rule 1 fills, ovf on the full cycle, rule 2 empties
  task automatic test_saturation();
    exp_t e;
    logic [1:0] tab [8];
    tab = '{2'd1, 2'd2, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    clr_pulse();
    gtr = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      sb.push_back(mk(tab[i], 0, 0, 0, {3'b0, i >= 2}));
      tick();
      e = sb.pop_front();
      checks++;
      if ({skid_lvl_o, isColAddr_skid_o, skid_ovf_o} !== e) begin
        errors++;
        $display("FAIL saturation edge%0d got=%h exp=%h", i + 1,
                 {skid_lvl_o, isColAddr_skid_o, skid_ovf_o}, e);
      end
    end
  endtask

  // continues from saturation: clear beats en with isGtr still high
  task automatic test_clear();
    exp_t e;
    clr_i = 1'b1; en_i = 1'b1; gtr = 4'b0001;
    sb.push_back(mk(0, 0, 0, 0, 4'b0));
    tick();
    e = sb.pop_front();
    checks++;
    if ({skid_lvl_o, isColAddr_skid_o, skid_ovf_o} !== e) begin
      errors++;
      $display("FAIL clear_priority got=%h exp=%h", {skid_lvl_o, isColAddr_skid_o, skid_ovf_o}, e);
    end
    clr_i = 1'b0; gtr = '0;
  endtask

  // ch1: rule1 beats rule3 while below depth, then rule3 releases when full
  task automatic test_rule3();
    exp_t e;
    logic [3:0] g [4];
    logic       p [4];
    logic [1:0] l [4];
    g = '{4'b0010, 4'b0010, 4'b0000, 4'b0010};
    p = '{1'b1, 1'b0, 1'b0, 1'b1};
    l = '{2'd1, 2'd2, 2'd2, 2'd0};
    clr_pulse();
    for (int i = 0; i < 4; i++) begin
      gtr = g[i]; pcb = p[i];
      sb.push_back(mk(0, l[i], 0, 0, 4'b0));
      tick();
      e = sb.pop_front();
      checks++;
      if ({skid_lvl_o, isColAddr_skid_o, skid_ovf_o} !== e) begin
        errors++;
        $display("FAIL rule3 step%0d got=%h exp=%h", i,
                 {skid_lvl_o, isColAddr_skid_o, skid_ovf_o}, e);
      end
    end
    gtr = '0; pcb = 1'b0;
  endtask

  // ch2: stall freezes, an idle enabled cycle breaks the run so rule 2
  // needs a fresh 3-cycle history before releasing
  task automatic test_stall();
    exp_t e;
    logic       en [13];
    logic       g  [13];
    logic [1:0] l  [13];
    logic       o  [13];
    en = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    g  = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    l  = '{1, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 0, 0};
    o  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    clr_pulse();
    for (int i = 0; i < 13; i++) begin
      en_i = en[i];
      gtr  = {1'b0, g[i], 2'b00};
      sb.push_back(mk(0, 0, l[i], 0, {1'b0, o[i], 2'b00}));
      tick();
      e = sb.pop_front();
      checks++;
      if ({skid_lvl_o, isColAddr_skid_o, skid_ovf_o} !== e) begin
        errors++;
        $display("FAIL stall step%0d got=%h exp=%h", i,
                 {skid_lvl_o, isColAddr_skid_o, skid_ovf_o}, e);
      end
    end
    en_i = 1'b1; gtr = '0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    logic [1:0] l [3];
    l = '{2'd1, 2'd2, 2'd2};
    clr_pulse();
    gtr = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(l[i], 0, 0, 0, {3'b0, i == 2}));
      tick();
      e = sb.pop_front();
      checks++;
      if ({skid_lvl_o, isColAddr_skid_o, skid_ovf_o} !== e) begin
        errors++;
        $display("FAIL areset_fill step%0d got=%h exp=%h", i,
                 {skid_lvl_o, isColAddr_skid_o, skid_ovf_o}, e);
      end
    end
    // mid-cycle assertion, no clock edge in between
    #2;
    rst = 1'b1;
    sb.push_back(mk(0, 0, 0, 0, 4'b0));
    #1;
    e = sb.pop_front();
    checks++;
    if ({skid_lvl_o, isColAddr_skid_o, skid_ovf_o} !== e) begin
      errors++;
      $display("FAIL areset_immediate got=%h exp=%h", {skid_lvl_o, isColAddr_skid_o, skid_ovf_o}, e);
    end
    tick();
    rst = 1'b0; gtr = '0;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(0, 0, 0, 0, 4'b0));
      tick();
      e = sb.pop_front();
      checks++;
      if ({skid_lvl_o, isColAddr_skid_o, skid_ovf_o} !== e) begin
        errors++;
        $display("FAIL areset_idle step%0d got=%h exp=%h", i,
                 {skid_lvl_o, isColAddr_skid_o, skid_ovf_o}, e);
      end
    end
    gtr = 4'b0001;
    sb.push_back(mk(1, 0, 0, 0, 4'b0));
    tick();
    e = sb.pop_front();
    checks++;
    if ({skid_lvl_o, isColAddr_skid_o, skid_ovf_o} !== e) begin
      errors++;
      $display("FAIL areset_restart got=%h exp=%h", {skid_lvl_o, isColAddr_skid_o, skid_ovf_o}, e);
    end
    gtr = '0;
  endtask

  // single-stage reference: skid bit set on isGtr when idle, dropped after a
  // 3-long isGtr streak or on isGtr with pipeline begin
  task automatic test_legacy();
    int  m_skid, m_streak;
    bit  g, p, en, exp_col;
    l_en = 1'b1; l_clr = 1'b1; l_gtr = '0; l_pcb = 1'b0;
    tick();
    l_clr = 1'b0;
    m_skid = 0; m_streak = 0;
    for (int i = 0; i < 10000; i++) begin
      g  = 1'($urandom_range(0, 1));
      p  = ($urandom_range(0, 3) == 0);
      en = ($urandom_range(0, 7) != 0);
      l_gtr[0] = g; l_pcb = p; l_en = en;
      if (en) begin
        if (g && m_skid == 0)  m_skid = 1;
        else if (m_streak >= 3) m_skid = 0;
        else if (g && p)       m_skid = 0;
        m_streak = g ? ((m_streak >= 3) ? 3 : m_streak + 1) : 0;
      end
      exp_col = (m_skid != 0);
      lsb.push_back(exp_col);
      tick();
      checks++;
      if (l_col[0] !== lsb.pop_front()) begin
        errors++;
        $display("FAIL legacy cyc%0d got=%b exp=%b", i, l_col[0], exp_col);
      end
    end
    l_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_clear();
    test_rule3();
    test_stall();
    test_async_reset();
    test_legacy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
